instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, giving the number of output buffer entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an instruction field set is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the offer this cycle.
REQ-006 The block SHALL have port fmt, input, 3 bits: instruction format, 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-007 The block SHALL have ports opcode, input, 7 bits; rd, rs1 and rs2, input, 5 bits each; funct3, input, 3 bits; funct7, input, 7 bits: the RV32I instruction fields.
REQ-008 The block SHALL have port imm, input, 32 bits: the signed immediate value.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the buffer head holds an encoded word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head.
REQ-011 The block SHALL have port instr, output, 32 bits: the encoded instruction at the buffer head.
REQ-012 The block SHALL have port err, output, 1 bit: the head entry failed the range check.
REQ-013 The block SHALL have ports enc_count and err_count, output, 16 bits each: accepted instructions and flagged errors.

Function
REQ-014 An offer SHALL be accepted when in_valid and in_ready are both 1; out_valid, instr and err SHALL then be visible on the next cycle (latency 1).
REQ-015 in_ready SHALL equal the registered not-full state; a pop in the same cycle SHALL NOT raise in_ready while the buffer is full.
REQ-016 A pop SHALL occur when out_valid and out_ready are both 1; out_valid SHALL be 0 when the buffer is empty.
REQ-017 Simultaneous push and pop on a non-full buffer SHALL keep the occupancy unchanged, and the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The instr bit-packing by format SHALL be:
- common fields: opcode in bits [6:0] for every format.
- R: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7].
- I: imm[11:0] to bits [31:20]; rs1, funct3 and rd as for R.
- S: imm[11:5] to bits [31:25]; imm[4:0] to bits [11:7].
- B: imm[12] to bit [31]; imm[10:5] to [30:25]; imm[4:1] to [11:8]; imm[11] to [7].
- U: imm[31:12] to bits [31:12]; rd to [11:7].
- J: imm[20] to bit [31]; imm[10:1] to [30:21]; imm[11] to [20]; imm[19:12] to [19:12]; rd to [11:7].
REQ-019 Fields unused by a format SHALL be ignored.
REQ-020 An illegal fmt SHALL encode as 32'h00000000 with err=1, regardless of REQ-031.
REQ-021 The range check SHALL flag err=1 in these cases:
- I and S: imm outside -2048..2047.
- B: imm outside -4096..4094, or imm[0]=1.
- J: imm outside -1048576..1048574, or imm[0]=1.
- U: imm[11:0] not zero.
REQ-022 A flagged word SHALL still be packed per REQ-018 with the immediate truncated, and SHALL still be enqueued.
REQ-023 enc_count SHALL increment by 1 per accept, and err_count SHALL increment by 1 per accept with err=1.
REQ-024 Both counters SHALL wrap from 16'hFFFF to 0.

Reset
REQ-025 While reset=1 the buffer SHALL be flushed, and any entry in flight SHALL be discarded.
REQ-026 While reset=1, out_valid SHALL be 0, instr SHALL be 32'h0 and err SHALL be 0.
REQ-027 While reset=1 both counters SHALL be 0.
REQ-028 in_ready SHALL be 0 during reset and SHALL be 1 on the first cycle after reset deasserts.
REQ-029 An offer made while reset=1 SHALL NOT be accepted.

Configuration
REQ-030 Macro INSTR_ENC_RANGE_CHECK_EN, when defined, SHALL enable REQ-021 and err_count.
REQ-031 When INSTR_ENC_RANGE_CHECK_EN is undefined, err SHALL be set only by REQ-020, err_count SHALL be tied to 0, and immediates SHALL be silently truncated.

Structure
REQ-032 Package instr_enc_pkg SHALL hold the fmt enum, the opcode constants, the range limit constants and the buffer entry struct {instr, err}.
REQ-033 The output buffer SHALL be the sub-module instr_enc_fifo, parameterised by FIFO_DEPTH.

Verification
REQ-034 Directed scenarios SHALL include I-type encoding:
- fmt=I, opcode=7'b0010011, rd=rs1=funct3=0, imm=1: instr=32'h00100013, err=0.
- same fields with imm=-1: instr=32'hfff00013.
- same fields with imm=-2048: instr=32'h80000013.
- same fields with imm=2048, INSTR_ENC_RANGE_CHECK_EN defined: err=1, err_count=1.
REQ-035 Directed scenarios SHALL include fmt=B, opcode=7'b1100011, rs1=1, rs2=2, funct3=0, imm=8: instr=32'h00208463; with imm=9, err=1.
REQ-036 Directed scenarios SHALL include fmt=U, opcode=7'b0110111, rd=5, imm=32'h12345000: instr=32'h123452B7, err=0.
REQ-037 Directed scenarios SHALL include backpressure:
- out_ready=0 with 3 offers: exactly FIFO_DEPTH accepted, then in_ready=0.
- then out_ready=1: words emerge in acceptance order, and in_ready returns one cycle after the first pop.
REQ-038 Directed scenarios SHALL include a reset pulse with the buffer full: the next cycle shows out_valid=0, enc_count=0, in_ready=1.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared types and constants for the RV32I instruction encoder:
//   - fmt_e       : instruction format selector (R/I/S/B/U/J; 6 and 7 illegal)
//   - OPC_*       : base RV32I major opcodes
//   - IMM*_MIN/MAX: signed immediate limits used by the optional range check
//   - enc_entry_t : one output buffer entry {instr, err}
//   - in_range()  : signed inclusive range test
// -----------------------------------------------------------------------------
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Branch and jump offsets are even, so their upper limits stop one short.
  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMMB_MIN  = -4096;
  localparam int signed IMMB_MAX  = 4094;
  localparam int signed IMMJ_MIN  = -1048576;
  localparam int signed IMMJ_MAX  = 1048574;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_entry_t;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input int signed lo,
                                    input int signed hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// -----------------------------------------------------------------------------
// instr_enc_fifo
// Output buffer of encoded words. DEPTH entries (power of two, >= 2); read and
// write pointers wrap naturally modulo DEPTH. Head is visible the cycle after
// a push into an empty buffer.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (flushes pointers)
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : entry to enqueue
//   pop_i         : drop the head entry (ignored when empty)
//   full_o        : registered occupancy == DEPTH
//   empty_o       : registered occupancy == 0
//   head_o        : entry at the read pointer
// -----------------------------------------------------------------------------
module instr_enc_fifo
  import instr_enc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  enc_entry_t push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output enc_entry_t head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             wr_en, rd_en;

  enc_entry_t mem_q [DEPTH];

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count decide
  // what is valid, and a reset here would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Packs RV32I instruction fields into a 32-bit word according to fmt and
// queues {instr, err} in an output buffer (latency 1 from accept to head).
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN enables the immediate
// range check and err_count; without it err flags illegal fmt only and
// err_count stays 0.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   in_valid / in_ready    : input handshake (in_ready = registered not-full)
//   fmt                    : 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, rd, rs1, rs2,
//   funct3, funct7, imm    : instruction fields
//   out_valid / out_ready  : output handshake on the buffer head
//   instr, err             : head word and its error flag
//   enc_count, err_count   : wrapping counters of accepts and flagged accepts
// -----------------------------------------------------------------------------
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic       fmt_illegal, range_err;
  enc_entry_t enc_d, head;

  logic [15:0] enc_count_q, enc_count_d;

  // Offers and head are masked during reset so nothing is taken or shown
  // before the synchronous flush has landed.
  assign in_ready  = !fifo_full && !reset;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty && !reset;
  assign pop       = out_valid && out_ready;
  assign instr     = out_valid ? head.instr : '0;
  assign err       = out_valid && head.err;

  // Bit packing. Fields a format does not use are simply not selected.
  always_comb begin
    enc_d.instr = '0;
    fmt_illegal = 1'b0;
    case (fmt_e'(fmt))
      FMT_R: enc_d.instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: enc_d.instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: enc_d.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: enc_d.instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
      FMT_U: enc_d.instr = {imm[31:12], rd, opcode};
      FMT_J: enc_d.instr = {imm[20], imm[10:1], imm[11], imm[19:12],
                            rd, opcode};
      default: fmt_illegal = 1'b1;
    endcase
    enc_d.err = fmt_illegal || range_err;
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  logic [15:0]        err_count_q, err_count_d;

  assign imm_s = $signed(imm);

  // Out-of-range words are still packed (truncated) and enqueued; only the
  // flag marks them.
  always_comb begin
    range_err = 1'b0;
    case (fmt_e'(fmt))
      FMT_I, FMT_S: range_err = !in_range(imm_s, IMM12_MIN, IMM12_MAX);
      FMT_B:        range_err = !in_range(imm_s, IMMB_MIN, IMMB_MAX) || imm[0];
      FMT_J:        range_err = !in_range(imm_s, IMMJ_MIN, IMMJ_MAX) || imm[0];
      FMT_U:        range_err = |imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    if (push && enc_d.err) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = reset ? '0 : err_count_q;
`else
  assign range_err = 1'b0;
  assign err_count = '0;
`endif

  always_comb begin
    enc_count_d = enc_count_q;
    if (push) enc_count_d = enc_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) enc_count_q <= '0;
    else       enc_count_q <= enc_count_d;
  end

  assign enc_count = reset ? '0 : enc_count_q;

  instr_enc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (enc_d),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder. A queue-based reference model tracks
// buffer contents and counters; encodings are computed with shifts and masks
// straight from the field placement rules. Works with or without
// INSTR_ENC_RANGE_CHECK_EN defined.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int DEPTH = 2;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [15:0] enc_count, err_count;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: {instr, err} entries in order, plus counters.
  logic [32:0] sb[$];
  logic [15:0] m_enc = '0;
  logic [15:0] m_err = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi,
                                      input int lo, input int pos);
    logic [31:0] mask;
    mask = (32'd1 << (hi - lo + 1)) - 32'd1;
    return ((v >> lo) & mask) << pos;
  endfunction

  function automatic logic [32:0] model_enc(input int f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    int          si;
    logic [31:0] w;
    logic [31:0] regs;
    bit          bad;
    si   = im;
    bad  = 1'b0;
    regs = fld(32'(s1), 4, 0, 15) | fld(32'(f3), 2, 0, 12);
    case (f)
      0: w = fld(32'(f7), 6, 0, 25) | fld(32'(s2), 4, 0, 20) | regs
           | fld(32'(d), 4, 0, 7) | 32'(op);
      1: begin
        w   = fld(im, 11, 0, 20) | regs | fld(32'(d), 4, 0, 7) | 32'(op);
        bad = (si < -2048) || (si > 2047);
      end
      2: begin
        w   = fld(im, 11, 5, 25) | fld(32'(s2), 4, 0, 20) | regs
            | fld(im, 4, 0, 7) | 32'(op);
        bad = (si < -2048) || (si > 2047);
      end
      3: begin
        w   = fld(im, 12, 12, 31) | fld(im, 10, 5, 25) | fld(32'(s2), 4, 0, 20)
            | regs | fld(im, 4, 1, 8) | fld(im, 11, 11, 7) | 32'(op);
        bad = (si < -4096) || (si > 4094) || (si % 2 != 0);
      end
      4: begin
        w   = (im & 32'hFFFF_F000) | fld(32'(d), 4, 0, 7) | 32'(op);
        bad = (im % 4096) != 0;
      end
      5: begin
        w   = fld(im, 20, 20, 31) | fld(im, 10, 1, 21) | fld(im, 11, 11, 20)
            | fld(im, 19, 12, 12) | fld(32'(d), 4, 0, 7) | 32'(op);
        bad = (si < -1048576) || (si > 1048574) || (si % 2 != 0);
      end
      default: w = 32'h0;
    endcase
    return {w, (f > 5) || (RANGE_EN && bad)};
  endfunction

  function automatic logic [31:0] rand_imm();
    int b[10];
    b = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098, 1048574, -1048576};
    case ($urandom_range(0, 4))
      0:       return $urandom();
      1:       return 32'(int'($urandom_range(0, 8191)) - 4096);
      2:       return 32'(b[$urandom_range(0, 9)] + int'($urandom_range(0, 1)));
      3:       return $urandom() & 32'hFFFF_F000;
      default: return 32'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rand_fields();
    fmt    = 3'($urandom_range(0, 7));
    opcode = 7'($urandom());
    rd     = 5'($urandom());
    rs1    = 5'($urandom());
    rs2    = 5'($urandom());
    funct3 = 3'($urandom());
    funct7 = 7'($urandom());
    imm    = rand_imm();
  endtask

  // One clock cycle with the currently driven inputs: compare outputs with
  // the model, then advance both the DUT and the model.
  task automatic cycle();
    bit          exp_ready, exp_valid, do_push, do_pop;
    logic [32:0] e;
    exp_ready = (sb.size() < DEPTH);
    exp_valid = (sb.size() > 0);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("head instr", instr, sb[0][32:1]);
      check("head err", 32'(err), 32'(sb[0][0]));
    end
    check("enc_count", 32'(enc_count), 32'(m_enc));
    check("err_count", 32'(err_count), 32'(m_err));
    do_push = in_valid && exp_ready;
    do_pop  = out_ready && exp_valid;
    e = model_enc(int'(fmt), opcode, rd, rs1, rs2, funct3, funct7, imm);
    @(posedge clk);
    #1;
    if (do_pop) void'(sb.pop_front());
    if (do_push) begin
      sb.push_back(e);
      m_enc++;
      if (RANGE_EN && e[0]) m_err++;
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    rand_fields();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst instr", instr, 32'h0);
    check("rst err", 32'(err), 32'd0);
    check("rst enc_count", 32'(enc_count), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    sb.delete();
    m_enc = '0;
    m_err = '0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'd1);
    check("post-rst out_valid", 32'(out_valid), 32'd0);
    check("post-rst enc_count", 32'(enc_count), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [2:0] f,
      input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im, input logic [31:0] exp_instr, input logic exp_err);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    check({tag, " instr"}, instr, exp_instr);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0;

    apply_reset(3);

    // I-type: rs2/funct7 carry junk that must be ignored.
    directed("I imm=1",     3'd1, 7'b0010011, 5'd0, 5'd0, 5'd17, 3'd0, 7'h55,
             32'd1, 32'h00100013, 1'b0);
    directed("I imm=-1",    3'd1, 7'b0010011, 5'd0, 5'd0, 5'd9, 3'd0, 7'h2A,
             32'hFFFF_FFFF, 32'hFFF00013, 1'b0);
    directed("I imm=-2048", 3'd1, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
             32'hFFFF_F800, 32'h80000013, 1'b0);
    directed("I imm=2048",  3'd1, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
             32'd2048, 32'h80000013, RANGE_EN);
    check("I imm=2048 err_count", 32'(err_count), 32'(RANGE_EN));

    directed("B imm=8", 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00,
             32'd8, 32'h00208463, 1'b0);
    directed("B imm=9", 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00,
             32'd9, 32'h00208463, RANGE_EN);
    directed("U lui",   3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00,
             32'h12345000, 32'h123452B7, 1'b0);
    directed("fmt=6",   3'd6, 7'b0110011, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20,
             32'd4, 32'h0, 1'b1);
    directed("fmt=7",   3'd7, 7'b0010011, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20,
             32'd4, 32'h0, 1'b1);

    // Backpressure: three offers into a stalled buffer, then drain in order.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (3) begin
      rand_fields();
      cycle();
    end
    in_valid = 1'b0;
    check("bp in_ready", 32'(in_ready), 32'd0);
    check("bp accepted", 32'(enc_count), 32'(m_enc));
    out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    out_ready = 1'b0;

    // Reset with a full buffer.
    in_valid = 1'b1;
    repeat (DEPTH) begin
      rand_fields();
      cycle();
    end
    in_valid = 1'b0;
    check("full before reset", 32'(in_ready), 32'd0);
    apply_reset(1);

    // Random traffic with random back-pressure.
    repeat (400) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
